// File: rtl/alarm_ctrl_pkg.sv
// Alarm controller shared definitions.
// Command encodings and per-channel state type.
package alarm_ctrl_pkg;

  localparam logic [1:0] CMD_ARM_ONESHOT  = 2'b00;
  localparam logic [1:0] CMD_ARM_PERIODIC = 2'b01;
  localparam logic [1:0] CMD_DISARM       = 2'b10;
  localparam logic [1:0] CMD_RSVD         = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ONESHOT  = 2'd1,
    ST_PERIODIC = 2'd2
  } ch_state_e;

  function automatic logic cmd_is_legal(
    input logic [1:0] cmd
  );
    return cmd != CMD_RSVD;
  endfunction

endpackage

// File: rtl/alarm_ctrl_channel.sv
// One alarm channel: arm/disarm FSM, periodic reload,
// hit blanking and sticky pending/overrun flags.
module alarm_ctrl_channel
  import alarm_ctrl_pkg::*;
#(
  parameter int TW = 32
) (
  input  logic          clk_i,
  input  logic          rst_an_i,
  input  logic          i_we,
  input  logic [1:0]    i_cmd,
  input  logic [TW-1:0] i_value,
  input  logic [TW-1:0] i_period,
  input  logic          i_hit,
  input  logic          i_ack,
  output logic          o_en,
  output logic [TW-1:0] o_val,
  output logic          o_pending,
  output logic          o_overrun
);

  ch_state_e     r_state;
  ch_state_e     w_state_nx;
  logic [TW-1:0] r_val;
  logic [TW-1:0] w_val_nx;
  logic [TW-1:0] r_per;
  logic [TW-1:0] w_per_nx;
  logic          r_blank;
  logic          w_blank_nx;
  logic          r_pend;
  logic          r_ovr;
  logic          w_vhit;

  // Generator still compares against the old value for one cycle.
  assign w_vhit = i_hit & (r_state != ST_IDLE) & ~r_blank;

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      r_state <= ST_IDLE;
      r_val   <= '0;
      r_per   <= '0;
      r_blank <= 1'b0;
      r_pend  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_val   <= w_val_nx;
      r_per   <= w_per_nx;
      r_blank <= w_blank_nx;
      if (i_ack) begin
        r_pend <= w_vhit;
        r_ovr  <= 1'b0;
      end else begin
        r_pend <= r_pend | w_vhit;
        r_ovr  <= r_ovr | (w_vhit & r_pend);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_val_nx   = r_val;
    w_per_nx   = r_per;
    w_blank_nx = 1'b0;
    unique case (r_state)
      ST_ONESHOT: begin
        if (w_vhit) w_state_nx = ST_IDLE;
      end
      ST_PERIODIC: begin
        if (w_vhit) begin
          w_val_nx   = r_val + r_per;
          w_blank_nx = 1'b1;
        end
      end
      default: ;
    endcase
    // A same-cycle command overrides the hit's effect on state/value.
    if (i_we) begin
      unique case (1'b1)
        (i_cmd == CMD_ARM_ONESHOT): begin
          w_state_nx = ST_ONESHOT;
          w_val_nx   = i_value;
          w_blank_nx = 1'b1;
        end
        (i_cmd == CMD_ARM_PERIODIC): begin
          w_state_nx = (i_period == '0) ? ST_ONESHOT
                                        : ST_PERIODIC;
          w_val_nx   = i_value;
          w_per_nx   = i_period;
          w_blank_nx = 1'b1;
        end
        (i_cmd == CMD_DISARM): begin
          w_state_nx = ST_IDLE;
          w_val_nx   = r_val;
          w_blank_nx = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_en      = (r_state != ST_IDLE);
  assign o_val     = r_val;
  assign o_pending = r_pend;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/alarm_controller.sv
// Multi-channel alarm controller: command decode,
// channel array, error pulse and interrupt output.
module alarm_controller
  import alarm_ctrl_pkg::*;
#(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_CAPTURES    = 10,
  localparam int CHW = $clog2(NB_CAPTURES),
  localparam int TW  = TIMER_BITWIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_an_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [CHW-1:0]            cfg_ch_i,
  input  logic [1:0]                cfg_cmd_i,
  input  logic [TW-1:0]             cfg_value_i,
  input  logic [TW-1:0]             cfg_period_i,
  output logic                      cfg_err_o,
  input  logic [NB_CAPTURES-1:0]    hit_i,
  output logic [NB_CAPTURES-1:0]    alarm_en_o,
  output logic [TW*NB_CAPTURES-1:0] alarm_val_o,
  input  logic [NB_CAPTURES-1:0]    irq_ack_i,
  output logic [NB_CAPTURES-1:0]    irq_pending_o,
  output logic [NB_CAPTURES-1:0]    overrun_o,
  output logic                      irq_o
);

  logic                   r_ready;
  logic                   r_err;
  logic                   r_irq;
  logic                   w_acc;
  logic                   w_ch_ok;
  logic                   w_cmd_ok;
  logic [NB_CAPTURES-1:0] w_we;

  assign w_acc    = cfg_valid_i & r_ready;
  assign w_ch_ok  = ({1'b0, cfg_ch_i} < (CHW+1)'(NB_CAPTURES));
  assign w_cmd_ok = w_acc & w_ch_ok & cmd_is_legal(cfg_cmd_i);

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_acc & ~(w_ch_ok & cmd_is_legal(cfg_cmd_i));
      r_irq   <= |irq_pending_o;
    end
  end

  for (genvar g = 0; g < NB_CAPTURES; g++) begin : g_ch
    assign w_we[g] = w_cmd_ok & (cfg_ch_i == CHW'(g));

    alarm_ctrl_channel #(
      .TW(TW)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_an_i  (rst_an_i),
      .i_we      (w_we[g]),
      .i_cmd     (cfg_cmd_i),
      .i_value   (cfg_value_i),
      .i_period  (cfg_period_i),
      .i_hit     (hit_i[g]),
      .i_ack     (irq_ack_i[g]),
      .o_en      (alarm_en_o[g]),
      .o_val     (alarm_val_o[g*TW +: TW]),
      .o_pending (irq_pending_o[g]),
      .o_overrun (overrun_o[g])
    );
  end

  assign cfg_ready_o = r_ready;
  assign cfg_err_o   = r_err;
  assign irq_o       = r_irq;

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter TIMER_BITWIDTH, default 32, width of alarm values, periods and counters.
REQ-002 Parameter NB_CAPTURES, default 10, number of alarm channels.
REQ-003 clk_i  input  1  clock; all logic on rising edge.
REQ-004 rst_an_i  input  1  reset, asynchronous, active-low.
REQ-005 cfg_valid_i  input  1  configuration command valid.
REQ-006 cfg_ready_o  output  1  command accepted when cfg_valid_i & cfg_ready_o.
REQ-007 cfg_ch_i  input  $clog2(NB_CAPTURES)  target channel.
REQ-008 cfg_cmd_i  input  2  00 ARM_ONESHOT, 01 ARM_PERIODIC, 10 DISARM, 11 reserved.
REQ-009 cfg_value_i  input  TIMER_BITWIDTH  first alarm match value.
REQ-010 cfg_period_i  input  TIMER_BITWIDTH  reload increment, periodic mode.
REQ-011 cfg_err_o  output  1  one-cycle pulse: accepted command with channel >= NB_CAPTURES or cmd 11.
REQ-012 hit_i  input  NB_CAPTURES  per-channel match flags from the alarm generator.
REQ-013 alarm_en_o  output  NB_CAPTURES  per-channel enable to the alarm generator.
REQ-014 alarm_val_o  output  TIMER_BITWIDTH*NB_CAPTURES  packed alarm values, channel i at bits [i*TIMER_BITWIDTH +: TIMER_BITWIDTH].
REQ-015 irq_ack_i  input  NB_CAPTURES  per-channel pending clear.
REQ-016 irq_pending_o  output  NB_CAPTURES  sticky per-channel hit flags.
REQ-017 overrun_o  output  NB_CAPTURES  sticky: hit while already pending.
REQ-018 irq_o  output  1  registered OR of irq_pending_o.

Function
REQ-019 Per-channel state machine: IDLE, ONESHOT, PERIODIC; alarm_en_o[i]=1 exactly in ONESHOT/PERIODIC (registered, state-decoded).
REQ-020 cfg_ready_o SHALL be 1 in every cycle out of reset; one command accepted per cycle.
REQ-021 ARM_ONESHOT: next cycle value <= cfg_value_i, state ONESHOT, from any state.
REQ-022 ARM_PERIODIC: next cycle value <= cfg_value_i, period <= cfg_period_i, state PERIODIC; cfg_period_i=0 SHALL arm as ONESHOT.
REQ-023 DISARM: next cycle state IDLE; value and pending unchanged.
REQ-024 Invalid channel or cmd 11: no state change; cfg_err_o=1 next cycle.
REQ-025 Blanking: hit_i[i] SHALL be ignored in the first cycle after channel i is armed or reloaded (generator output reflects previous value).
REQ-026 hit_i[i] in IDLE or blanking cycle: ignored.
REQ-027 Valid hit in ONESHOT: next cycle state IDLE, pending[i] set.
REQ-028 Valid hit in PERIODIC: next cycle value <= value + period modulo 2^TIMER_BITWIDTH (wrap, no saturation), pending[i] set, state stays PERIODIC.
REQ-029 Valid hit with pending[i] already 1 and no same-cycle ack: overrun[i] set.
REQ-030 irq_ack_i[i] clears pending[i] and overrun[i] next cycle; same-cycle valid hit: pending stays 1, overrun unchanged (cleared).
REQ-031 Config and valid hit same channel same cycle: config determines state/value; hit still sets pending/overrun.
REQ-032 irq_o SHALL lag irq_pending_o by one cycle.

Reset
REQ-033 rst_an_i low SHALL immediately force: all states IDLE, alarm_en_o=0, alarm_val_o=0, periods=0, irq_pending_o=0, overrun_o=0, irq_o=0, cfg_err_o=0, cfg_ready_o=0; cfg_ready_o=1 from first clock edge after release.
REQ-034 Reset mid-operation SHALL discard armed channels; no hit after release sets pending until re-armed.

Structure
REQ-035 Package alarm_ctrl_pkg SHALL hold cmd encodings and the channel state enum.
REQ-036 Per-channel logic SHALL be sub-module alarm_ctrl_channel, instantiated NB_CAPTURES times via generate; top holds decode, irq_o, cfg_err_o.

Verification
REQ-037 ARM_ONESHOT ch2 value 100; hit_i[2] at counter 100 -> alarm_en_o[2] 1->0, irq_pending_o[2]=1, irq_o=1 one cycle later.
REQ-038 ARM_PERIODIC ch0 value 0xFFFF_FFF0 period 0x20; hit -> alarm_val ch0 = 0x0000_0010, en stays 1.
REQ-039 Two hits ch5 without ack -> overrun_o[5]=1; ack -> pending and overrun 0; ack with simultaneous hit -> pending 1, overrun 0.
REQ-040 hit_i[3] in cycle after arming ch3, and hit in IDLE -> pending unchanged 0.
REQ-041 cfg_ch_i=12 (NB=10) or cmd 11 -> cfg_err_o one-cycle pulse, all channel outputs unchanged.
REQ-042 Reset asserted while ch1 PERIODIC and pending -> all outputs 0 immediately; later hit_i[1] -> no pending.
